ro_puf_ctrl: RTL and testbench

Challenge/response sequencer for the ring-oscillator PUF. It drives the select lines of the two 16:1 RO multiplexers, enables the oscillator bank, and counts rising edges of both selected RO outputs over a fixed window. Each comparison yields one response bit; the block builds an NBITS-bit response word. It sits between the host challenge interface and the RO bank/mux datapath.

---
 rtl/ro_puf_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ro_puf_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF challenge/response sequencer: selects RO pairs, counts edges, builds a response word.
// Optional build macro RO_PUF_MAJORITY_EN: three measurements per pair with a 2-of-3 majority vote.
module ro_puf_ctrl #(
  parameter int NBITS  = 8,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [8*NBITS-1:0] challenge,
  input  logic               ro_a,
  input  logic               ro_b,
  output logic [3:0]         sel_a,
  output logic [3:0]         sel_b,
  output logic               ro_en,
  output logic               busy,
  output logic               done,
  output logic [NBITS-1:0]   response,
  output logic [2:0]         dbg_state
);

  // Handshake: start is sampled only in IDLE (no queuing); done is a one-cycle pulse
  // in the DONE state, and response stays valid from that cycle until the next DONE.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int KW = $clog2(NBITS + 1);
  localparam int TW = $clog2(((WINDOW > SETTLE) ? WINDOW : SETTLE) + 1);

  logic [2:0]         r_state;
  logic [KW-1:0]      r_k;
  logic [TW-1:0]      r_tmr;
  logic [8*NBITS-1:0] r_chal;
  logic [NBITS-1:0]   r_work;
  logic [NBITS-1:0]   r_resp;
  logic [3:0]         r_sel_a;
  logic [3:0]         r_sel_b;
  logic               r_force;
  logic [CNT_W-1:0]   r_cnt_a;
  logic [CNT_W-1:0]   r_cnt_b;
  logic [2:0]         r_sync_a;
  logic [2:0]         r_sync_b;
`ifdef RO_PUF_MAJORITY_EN
  logic [1:0]         r_pass;
  logic [1:0]         r_vote;
  logic [1:0]         w_votes;
`endif

  logic [7:0]       w_pair;
  logic             w_rise_a;
  logic             w_rise_b;
  logic             w_gt;
  logic             w_last;
  logic             w_bit;
  logic [NBITS-1:0] w_work_next;

  assign w_pair   = 8'(r_chal >> {r_k, 3'b000});
  assign w_rise_a = r_sync_a[1] & ~r_sync_a[2];
  assign w_rise_b = r_sync_b[1] & ~r_sync_b[2];
  assign w_gt     = r_cnt_a > r_cnt_b;
  assign w_last   = (r_k == KW'(NBITS - 1));

`ifdef RO_PUF_MAJORITY_EN
  assign w_votes = r_vote + {1'b0, w_gt};
  assign w_bit   = ~r_force & w_votes[1];
`else
  assign w_bit   = ~r_force & w_gt;
`endif
  assign w_work_next = r_work | (NBITS'(w_bit) << r_k);

  // Third flop of each chain is the previous-sample register for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[1:0], ro_a};
      r_sync_b <= {r_sync_b[1:0], ro_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (r_state == S_LOAD || r_state == S_SETTLE) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (r_state == S_MEASURE) begin
      if (w_rise_a && r_cnt_a != '1) r_cnt_a <= r_cnt_a + 1'b1;
      if (w_rise_b && r_cnt_b != '1) r_cnt_b <= r_cnt_b + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_tmr   <= '0;
      r_chal  <= '0;
      r_work  <= '0;
      r_resp  <= '0;
      r_sel_a <= '0;
      r_sel_b <= '0;
      r_force <= 1'b0;
`ifdef RO_PUF_MAJORITY_EN
      r_pass  <= '0;
      r_vote  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_chal  <= challenge;
            r_k     <= '0;
            r_work  <= '0;
`ifdef RO_PUF_MAJORITY_EN
            r_pass  <= '0;
            r_vote  <= '0;
`endif
          end
        end
        S_LOAD: begin
          r_sel_a <= w_pair[3:0];
          r_sel_b <= w_pair[7:4];
          // Identical oscillators cannot be compared meaningfully: skip straight to a 0 bit.
          if (w_pair[3:0] == w_pair[7:4]) begin
            r_force <= 1'b1;
            r_state <= S_COMPARE;
          end else begin
            r_force <= 1'b0;
            r_tmr   <= TW'(SETTLE - 1);
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_tmr == '0) begin
            r_tmr   <= TW'(WINDOW - 1);
            r_state <= S_MEASURE;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_MEASURE: begin
          if (r_tmr == '0) r_state <= S_COMPARE;
          else r_tmr <= r_tmr - 1'b1;
        end
        S_COMPARE: begin
          r_force <= 1'b0;
`ifdef RO_PUF_MAJORITY_EN
          if (!r_force && r_pass != 2'd2) begin
            r_pass  <= r_pass + 1'b1;
            r_vote  <= w_votes;
            r_state <= S_LOAD;
          end else begin
            r_pass <= '0;
            r_vote <= '0;
`endif
            r_work <= w_work_next;
            if (w_last) begin
              r_resp  <= w_work_next;
              r_state <= S_DONE;
            end else begin
              r_k     <= r_k + 1'b1;
              r_state <= S_LOAD;
            end
`ifdef RO_PUF_MAJORITY_EN
          end
`endif
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sel_a     = r_sel_a;
  assign sel_b     = r_sel_b;
  assign ro_en     = (r_state == S_SETTLE) || (r_state == S_MEASURE);
  assign busy      = (r_state == S_LOAD) || (r_state == S_SETTLE) ||
                     (r_state == S_MEASURE) || (r_state == S_COMPARE);
  assign done      = (r_state == S_DONE);
  assign response  = r_resp;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Self-checking bench for ro_puf_ctrl: clocked RO models, directed challenges, response scoreboard.
// A second instance with a 3-bit counter runs in lockstep to cover counter saturation.
module tb_ro_puf_ctrl;

  localparam int NBITS  = 4;
  localparam int WINDOW = 64;
  localparam int SETTLE = 4;
`ifdef RO_PUF_MAJORITY_EN
  localparam int PASSES = 3;
`else
  localparam int PASSES = 1;
`endif
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      challenge = '0;
  logic             ro_a, ro_b;
  logic [3:0]       sel_a, sel_b;
  logic             ro_en, busy, done;
  logic [NBITS-1:0] response;
  logic [2:0]       dbg_state;

  logic             sat_ro_en, sat_busy, sat_done;
  logic [3:0]       sat_sel_a, sat_sel_b;
  logic [NBITS-1:0] sat_response;
  logic [2:0]       sat_dbg_state;

  logic             osc [18] = '{default: 1'b0};
  int               osc_cnt [18] = '{default: 0};
  int               cmp_cnt = 0;
  int               swap_mode = 0;
  logic             swap;

  logic [NBITS-1:0] exp_q [$];
  int               n_chk = 0;
  int               n_fail = 0;

  ro_puf_ctrl #(.NBITS(NBITS), .CNT_W(8), .WINDOW(WINDOW), .SETTLE(SETTLE)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
    .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a), .sel_b(sel_b), .ro_en(ro_en),
    .busy(busy), .done(done), .response(response), .dbg_state(dbg_state)
  );

  ro_puf_ctrl #(.NBITS(NBITS), .CNT_W(3), .WINDOW(WINDOW), .SETTLE(SETTLE)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
    .ro_a(osc[16]), .ro_b(osc[17]), .sel_a(sat_sel_a), .sel_b(sat_sel_b), .ro_en(sat_ro_en),
    .busy(sat_busy), .done(sat_done), .response(sat_response), .dbg_state(sat_dbg_state)
  );

  // ---------------- clock / RO models ----------------
  always #5 clk = ~clk;

  // Periods in clk cycles; 16/17 feed the saturation instance (both overflow a 3-bit counter).
  function automatic int period(input int j);
    case (j)
      1:       return 10;
      2:       return 14;
      3:       return 30;
      16:      return 4;
      17:      return 6;
      default: return 20;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int j = 0; j < 18; j++) begin
      if (osc_cnt[j] == period(j) / 2 - 1) begin
        osc_cnt[j] <= 0;
        osc[j]     <= ~osc[j];
      end else begin
        osc_cnt[j] <= osc_cnt[j] + 1;
      end
    end
  end

  // Measurement-pass index within a run, used to make pair 0 swap speeds in chosen windows.
  always @(posedge clk) begin
    if (start && dbg_state == S_IDLE) cmp_cnt <= 0;
    else if (dbg_state == S_COMPARE)  cmp_cnt <= cmp_cnt + 1;
  end

  assign swap = (swap_mode == 1 && cmp_cnt == 1) || (swap_mode == 2 && cmp_cnt <= 1);
  assign ro_a = swap ? osc[sel_b] : osc[sel_a];
  assign ro_b = swap ? osc[sel_a] : osc[sel_b];

  // ---------------- reference model ----------------
  function automatic logic [NBITS-1:0] model_resp(input logic [31:0] chal);
    logic [NBITS-1:0] r;
    logic [7:0]       p;
    r = '0;
    for (int i = 0; i < NBITS; i++) begin
      p = chal[8*i +: 8];
      r[i] = (p[3:0] != p[7:4]) && (period(int'(p[3:0])) < period(int'(p[7:4])));
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [31:0] chal);
    int         n;
    logic [7:0] p;
    n = 1;
    for (int i = 0; i < NBITS; i++) begin
      p = chal[8*i +: 8];
      n += (p[3:0] == p[7:4]) ? 2 : PASSES * (SETTLE + WINDOW + 2);
    end
    return n;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_chal(input logic [31:0] chal, input bit disturb,
                          input logic [NBITS-1:0] exp_resp, input int exp_lat);
    int               lat;
    logic [NBITS-1:0] exp_v;
    exp_q.push_back(exp_resp);
    @(negedge clk);
    challenge = chal;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check("load_busy", busy, 1'b1);
    check("load_ro_en", ro_en, 1'b0);
    while (done !== 1'b1 && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (lat == 2 && chal[3:0] != chal[7:4]) begin
        check("settle_sel_a", sel_a, chal[3:0]);
        check("settle_sel_b", sel_b, chal[7:4]);
        check("settle_ro_en", ro_en, 1'b1);
      end
      if (disturb && lat == 10) begin
        start     = 1'b1;
        challenge = ~chal;
      end
      if (disturb && lat == 11) start = 1'b0;
    end
    check("latency", lat, exp_lat);
    check("done_busy", busy, 1'b0);
    exp_v = exp_q.pop_front();
    check("response", response, exp_v);
    check("sat_done", sat_done, 1'b1);
    check("sat_response", sat_response, '0);
    // start raised during DONE must not launch a new challenge
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("after_done_state", dbg_state, S_IDLE);
    check("after_done_done", done, 1'b0);
    check("response_hold", response, exp_v);
  endtask

  // ---------------- directed sequence ----------------
  localparam logic [31:0] C_BASIC = 32'h13121221;
  localparam logic [31:0] C_EQUAL = 32'h12553121;
  localparam logic [31:0] C_DIST  = 32'h23312112;
  localparam logic [31:0] C_MAJ   = 32'h12121221;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ro_en", ro_en, 1'b0);
    check("rst_sel", {sel_b, sel_a}, 8'h00);
    check("rst_response", response, '0);
    check("rst_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    run_chal(C_BASIC, 1'b0, model_resp(C_BASIC), model_lat(C_BASIC));
    run_chal(C_EQUAL, 1'b0, model_resp(C_EQUAL), model_lat(C_EQUAL));
    run_chal(C_DIST,  1'b1, model_resp(C_DIST),  model_lat(C_DIST));

    // Abort during the measurement window of bit 1.
    @(negedge clk);
    challenge = C_BASIC;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (PASSES * (SETTLE + WINDOW + 2) + 29) @(negedge clk);
    check("pre_abort_state", dbg_state, S_MEASURE);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_ro_en", ro_en, 1'b0);
    check("abort_response", response, '0);
    @(negedge clk);
    check("abort_state", dbg_state, S_IDLE);
    check("abort_sel", {sel_b, sel_a}, 8'h00);
    rst_n = 1'b1;
    run_chal(C_BASIC, 1'b0, model_resp(C_BASIC), model_lat(C_BASIC));

`ifdef RO_PUF_MAJORITY_EN
    swap_mode = 1;
    run_chal(C_MAJ, 1'b0, 4'b0001, model_lat(C_MAJ));
    swap_mode = 2;
    run_chal(C_MAJ, 1'b0, 4'b0000, model_lat(C_MAJ));
    swap_mode = 0;
`else
    run_chal(C_MAJ, 1'b0, model_resp(C_MAJ), model_lat(C_MAJ));
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
